// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the FMRT pipeline controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_e;

    localparam int unsigned EXP_NO_EXP     = 0;
    localparam int unsigned EXP_IRQ        = 11;
    localparam logic [31:0] EXP_ENTRY_ADDR = 32'h0000_0080;

    localparam logic ENABLE  = 1'b1;
    localparam logic ENABLE_ = 1'b0;

    // Width of one forwarding select: 0 = register file, k+1 = producer stage k.
    function automatic int unsigned fwd_sel_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Busy bit per GPR for results still owed by the multi-cycle unit.
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          hold_i,
    input  logic                          clr_all_i,
    input  logic                          set_i,
    input  logic [REG_ADDR_W-1:0]         set_addr_i,
    input  logic                          clr_i,
    input  logic [REG_ADDR_W-1:0]         clr_addr_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rd_addr_i,
    output logic [NUM_SRC-1:0]            rd_busy_o,
    input  logic [REG_ADDR_W-1:0]         wr_addr_i,
    output logic                          wr_busy_o
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Completion always retires; a same-address issue in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_addr_i] = ENABLE_;
        end
        if (!hold_i) begin
            if (clr_all_i) begin
                busy_d = '0;
            end else if (set_i && (set_addr_i != '0)) begin
                busy_d[set_addr_i] = ENABLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            rd_busy_o[k] = busy_q[rd_addr_i[k*REG_ADDR_W +: REG_ADDR_W]];
        end
        wr_busy_o = busy_q[wr_addr_i];
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: forwarding selects, hazard stalls/flushes, memory freeze and trap/ERET sequencing.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned EXP_W      = 4,
    localparam int unsigned FWD_SEL_W = fwd_sel_width(FWD_STAGES)
) (
    input  logic                             clk,
    input  logic                             reset_,
    input  logic [NUM_SRC-1:0]               src_used,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_addr,
    input  logic [FWD_STAGES-1:0]            fwd_en,
    input  logic [FWD_STAGES-1:0]            fwd_we_,
    input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_rd_addr,
    input  logic                             ex_is_load,
    input  logic                             mc_issue,
    input  logic [REG_ADDR_W-1:0]            mc_rd_addr,
    input  logic                             mc_done,
    input  logic [REG_ADDR_W-1:0]            mc_done_addr,
    input  logic                             mem_busy,
    input  logic                             br_taken,
    input  logic                             mem_en,
    input  logic [WORD_W-1:0]                mem_pc,
    input  logic [EXP_W-1:0]                 mem_exp_code,
    input  logic                             is_eret,
    input  logic                             irq,
    input  logic                             irq_en,
    input  logic [WORD_W-1:0]                mepc_i,
    output logic                             if_stall,
    output logic                             id_stall,
    output logic                             ex_stall,
    output logic                             mem_stall,
    output logic                             if_flush,
    output logic                             id_flush,
    output logic                             ex_flush,
    output logic                             mem_flush,
    output logic [NUM_SRC*FWD_SEL_W-1:0]     fwd_sel,
    output logic [WORD_W-1:0]                new_pc,
    output logic                             save_exp,
    output logic                             restore_exp,
    output logic [EXP_W-1:0]                 exp_code,
    output logic [WORD_W-1:0]                mepc_o,
    output logic                             mc_kill
);

    state_e state_q;
    state_e state_d;
    logic   irq_pend_q;
    logic   irq_pend_d;

    logic [NUM_SRC-1:0] src_busy;
    logic [NUM_SRC-1:0] src_fwd_ex;
    logic               mc_waw_busy;
    logic               load_use;
    logic               sb_hazard;
    logic               exc_take;
    logic               irq_take;
    logic               eret_take;
    logic               trap_take;
    logic               redirect;

    // Per operand, the nearest valid writer wins; iterate far-to-near so the nearest overwrites.
    always_comb begin
        fwd_sel    = '0;
        src_fwd_ex = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            for (int s = int'(FWD_STAGES) - 1; s >= 0; s--) begin
                if (src_used[k] && fwd_en[s] && (fwd_we_[s] == ENABLE_)
                    && (fwd_rd_addr[s*REG_ADDR_W +: REG_ADDR_W] != '0)
                    && (fwd_rd_addr[s*REG_ADDR_W +: REG_ADDR_W] == src_addr[k*REG_ADDR_W +: REG_ADDR_W])) begin
                    fwd_sel[k*FWD_SEL_W +: FWD_SEL_W] = FWD_SEL_W'(s + 1);
                end
            end
            src_fwd_ex[k] = (fwd_sel[k*FWD_SEL_W +: FWD_SEL_W] == FWD_SEL_W'(1));
        end
    end

    assign load_use  = ex_is_load && (|src_fwd_ex);
    assign sb_hazard = (|(src_used & src_busy)) || (mc_issue && mc_waw_busy);

    assign exc_take  = !mem_busy && mem_en && (mem_exp_code != EXP_W'(EXP_NO_EXP));
    assign irq_take  = !mem_busy && irq_pend_q && irq_en && (state_q == ST_RUN)
                       && mem_en && !exc_take && !is_eret;
    assign eret_take = !mem_busy && mem_en && is_eret && !exc_take;
    assign trap_take = exc_take || irq_take;

    pipe_scoreboard #(
        .NUM_SRC    (NUM_SRC),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset_     (reset_),
        .hold_i     (mem_busy),
        .clr_all_i  (trap_take),
        .set_i      (mc_issue),
        .set_addr_i (mc_rd_addr),
        .clr_i      (mc_done),
        .clr_addr_i (mc_done_addr),
        .rd_addr_i  (src_addr),
        .rd_busy_o  (src_busy),
        .wr_addr_i  (mc_rd_addr),
        .wr_busy_o  (mc_waw_busy)
    );

    // Memory freeze overrides everything, then trap, ERET, branch, and finally ID hazards.
    always_comb begin
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        ex_stall    = 1'b0;
        mem_stall   = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        mem_flush   = 1'b0;
        new_pc      = '0;
        save_exp    = 1'b0;
        restore_exp = 1'b0;
        exp_code    = EXP_W'(EXP_NO_EXP);
        mepc_o      = '0;
        mc_kill     = 1'b0;
        redirect    = 1'b0;
        if (mem_busy) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
        end else if (trap_take) begin
            {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
            save_exp = 1'b1;
            new_pc   = WORD_W'(EXP_ENTRY_ADDR);
            exp_code = exc_take ? mem_exp_code : EXP_W'(EXP_IRQ);
            mepc_o   = mem_pc;
            mc_kill  = 1'b1;
            redirect = 1'b1;
        end else if (eret_take) begin
            {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
            restore_exp = 1'b1;
            new_pc      = mepc_i;
            redirect    = 1'b1;
        end else if (br_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            redirect = 1'b1;
        end else if (load_use || sb_hazard) begin
            if_stall = 1'b1;
            id_flush = 1'b1;
        end
    end

    // SHADOW blocks interrupts until the redirected stream has advanced one unstalled cycle.
    always_comb begin
        state_d    = state_q;
        irq_pend_d = irq || (irq_pend_q && !irq_take);
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    state_d = ST_SHADOW;
                end
            end
            ST_SHADOW: begin
                if (!redirect && !if_stall) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= ST_RUN;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_pend_q <= irq_pend_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int NS = 2;
    localparam int FS = 2;
    localparam int AW = 5;
    localparam int SW = 2;
    localparam logic [31:0] ENTRY = 32'h0000_0080;
    localparam logic [3:0]  IRQ_CODE = 4'd11;

    logic clk, reset_;
    logic [NS-1:0] src_used;
    logic [NS*AW-1:0] src_addr;
    logic [FS-1:0] fwd_en, fwd_we_;
    logic [FS*AW-1:0] fwd_rd_addr;
    logic ex_is_load, mc_issue, mc_done, mem_busy, br_taken, mem_en, is_eret, irq, irq_en;
    logic [AW-1:0] mc_rd_addr, mc_done_addr;
    logic [31:0] mem_pc, mepc_i, new_pc, mepc_o;
    logic [3:0] mem_exp_code, exp_code;
    logic if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush;
    logic save_exp, restore_exp, mc_kill;
    logic [NS*SW-1:0] fwd_sel;

    pipe_ctrl dut (
        .clk(clk), .reset_(reset_), .src_used(src_used), .src_addr(src_addr),
        .fwd_en(fwd_en), .fwd_we_(fwd_we_), .fwd_rd_addr(fwd_rd_addr), .ex_is_load(ex_is_load),
        .mc_issue(mc_issue), .mc_rd_addr(mc_rd_addr), .mc_done(mc_done), .mc_done_addr(mc_done_addr),
        .mem_busy(mem_busy), .br_taken(br_taken), .mem_en(mem_en), .mem_pc(mem_pc),
        .mem_exp_code(mem_exp_code), .is_eret(is_eret), .irq(irq), .irq_en(irq_en), .mepc_i(mepc_i),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .fwd_sel(fwd_sel), .new_pc(new_pc), .save_exp(save_exp), .restore_exp(restore_exp),
        .exp_code(exp_code), .mepc_o(mepc_o), .mc_kill(mc_kill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: owed registers, pending interrupt, in redirect shadow.
    bit busy_m [32];
    bit pend_m;
    bit shadow_m;

    // Expected outputs of the current cycle; stall/flush packed as {mem, ex, id, if}.
    logic [3:0]     e_stall, e_flush;
    logic [NS*SW-1:0] e_fwd;
    logic [31:0]    e_newpc, e_mepc;
    logic [3:0]     e_code;
    logic           e_save, e_restore, e_kill;
    bit             e_trap, e_irqt, e_redirect;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        pend_m   = 1'b0;
        shadow_m = 1'b0;
    endtask

    task automatic check_model();
        int sel;
        bit exc, eret, lu, sb;
        logic [AW-1:0] a;
        if (!reset_) model_reset();
        e_fwd = '0; lu = 0; sb = 0;
        for (int k = 0; k < NS; k++) begin
            a = src_addr[k*AW +: AW];
            sel = 0;
            if (src_used[k]) begin
                for (int s = 0; s < FS; s++) begin
                    if (sel == 0 && fwd_en[s] && !fwd_we_[s] && a != 0 && fwd_rd_addr[s*AW +: AW] == a)
                        sel = s + 1;
                end
                if (busy_m[a]) sb = 1;
            end
            e_fwd[k*SW +: SW] = SW'(sel);
            if (sel == 1 && ex_is_load) lu = 1;
        end
        if (mc_issue && busy_m[mc_rd_addr]) sb = 1;
        exc    = !mem_busy && mem_en && mem_exp_code != 4'd0;
        e_irqt = !mem_busy && pend_m && irq_en && !shadow_m && mem_en && !exc && !is_eret;
        eret   = !mem_busy && mem_en && is_eret && !exc;
        e_trap = exc || e_irqt;
        e_stall = 4'h0; e_flush = 4'h0; e_newpc = 0; e_mepc = 0; e_code = 0;
        e_save = 0; e_restore = 0; e_kill = 0; e_redirect = 0;
        if (mem_busy) e_stall = 4'hF;
        else if (e_trap) begin
            e_flush = 4'hF; e_save = 1; e_newpc = ENTRY; e_kill = 1; e_redirect = 1;
            e_code = exc ? mem_exp_code : IRQ_CODE; e_mepc = mem_pc;
        end else if (eret) begin
            e_flush = 4'hF; e_restore = 1; e_newpc = mepc_i; e_redirect = 1;
        end else if (br_taken) begin
            e_flush = 4'b0011; e_redirect = 1;
        end else if (lu || sb) begin
            e_stall = 4'b0001; e_flush = 4'b0010;
        end
        chk("stalls", {mem_stall, ex_stall, id_stall, if_stall}, e_stall);
        chk("flushes", {mem_flush, ex_flush, id_flush, if_flush}, e_flush);
        chk("fwd_sel", fwd_sel, e_fwd);
        chk("trap_if", {new_pc, mepc_o, exp_code, save_exp, restore_exp, mc_kill},
            {e_newpc, e_mepc, e_code, e_save, e_restore, e_kill});
    endtask

    task automatic update_model();
        if (!reset_) begin
            model_reset();
            return;
        end
        if (mc_done) busy_m[mc_done_addr] = 1'b0;
        if (!mem_busy) begin
            if (e_trap) foreach (busy_m[i]) busy_m[i] = 1'b0;
            else if (mc_issue && mc_rd_addr != 0) busy_m[mc_rd_addr] = 1'b1;
        end
        if (irq) pend_m = 1'b1;
        else if (e_irqt) pend_m = 1'b0;
        if (e_redirect) shadow_m = 1'b1;
        else if (shadow_m && !e_stall[0]) shadow_m = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic idle();
        src_used = '0; src_addr = '0; fwd_en = '0; fwd_we_ = '1; fwd_rd_addr = '0;
        ex_is_load = 0; mc_issue = 0; mc_rd_addr = '0; mc_done = 0; mc_done_addr = '0;
        mem_busy = 0; br_taken = 0; mem_en = 0; mem_pc = '0; mem_exp_code = '0;
        is_eret = 0; irq = 0; irq_en = 0; mepc_i = '0;
    endtask

    task automatic rand_inputs();
        src_used = NS'($urandom_range(0, 3));
        src_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
        fwd_en = FS'($urandom_range(0, 3));
        fwd_we_ = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        fwd_rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
        ex_is_load = ($urandom_range(0, 3) == 0);
        mc_issue = ($urandom_range(0, 5) == 0);
        mc_rd_addr = AW'($urandom_range(0, 7));
        mc_done = ($urandom_range(0, 5) == 0);
        mc_done_addr = AW'($urandom_range(0, 7));
        mem_busy = ($urandom_range(0, 4) == 0);
        br_taken = ($urandom_range(0, 9) == 0);
        mem_en = ($urandom_range(0, 3) != 0);
        mem_pc = $urandom;
        mem_exp_code = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        is_eret = ($urandom_range(0, 14) == 0);
        irq = ($urandom_range(0, 7) == 0);
        irq_en = ($urandom_range(0, 2) != 0);
        mepc_i = $urandom;
    endtask

    initial begin
        reset_ = 1'b0;
        idle();
        model_reset();
        #1;
        settle();
        chk("rst_stalls", {mem_stall, ex_stall, id_stall, if_stall}, 4'h0);
        chk("rst_fwd", fwd_sel, 4'h0);
        advance();
        reset_ = 1'b1;
        cycle();

        // forwarding: both stages write x5, nearest wins; then only MEM
        fwd_en = 2'b11; fwd_we_ = 2'b00; fwd_rd_addr = {5'd5, 5'd5};
        src_used = 2'b01; src_addr = {5'd0, 5'd5};
        settle(); chk("fwd_ex", fwd_sel[1:0], 2'd1); advance();
        fwd_en = 2'b10;
        settle(); chk("fwd_mem", fwd_sel[1:0], 2'd2); advance();

        // load-use on op 1, then the load reaches MEM behind a bubble
        idle(); fwd_en = 2'b01; fwd_we_ = 2'b00; fwd_rd_addr = {5'd0, 5'd7}; ex_is_load = 1;
        src_used = 2'b10; src_addr = {5'd7, 5'd0};
        settle(); chk("lu_stall", if_stall, 1'b1); chk("lu_bubble", id_flush, 1'b1); advance();
        ex_is_load = 0; fwd_en = 2'b10; fwd_rd_addr = {5'd7, 5'd0};
        settle(); chk("lu_fwd", fwd_sel[3:2], 2'd2); chk("lu_go", if_stall, 1'b0); advance();

        // multi-cycle x9: ID stalled until the cycle after completion
        idle(); mc_issue = 1; mc_rd_addr = 5'd9; cycle();
        idle(); src_used = 2'b01; src_addr = {5'd0, 5'd9}; mc_done_addr = 5'd9;
        for (int c = 0; c < 10; c++) begin
            mc_done = (c == 5);
            settle(); chk("mc_stall", if_stall, (c <= 5)); advance();
        end

        // exception in MEM with x9 owed
        idle(); mc_issue = 1; mc_rd_addr = 5'd9; cycle();
        idle(); mem_en = 1; mem_exp_code = 4'd3; mem_pc = 32'h100; src_used = 2'b01; src_addr = {5'd0, 5'd9};
        settle();
        chk("exc_save", {save_exp, mc_kill, mem_flush, ex_flush, id_flush, if_flush}, 6'h3F);
        chk("exc_code", exp_code, 4'd3); chk("exc_mepc", mepc_o, 32'h100); chk("exc_pc", new_pc, ENTRY);
        advance();
        idle(); src_used = 2'b01; src_addr = {5'd0, 5'd9};
        settle(); chk("sb_cleared", if_stall, 1'b0); advance();

        // irq latched during memory freeze, taken on release
        idle(); mem_busy = 1; irq = 1;
        settle(); chk("busy_freeze", save_exp, 1'b0); advance();
        irq = 0; cycle();
        mem_busy = 0; mem_en = 1; irq_en = 1; mem_pc = 32'h140;
        settle(); chk("irq_take", {save_exp, exp_code}, {1'b1, IRQ_CODE}); chk("irq_mepc", mepc_o, 32'h140);
        advance();
        idle(); cycle();

        // masked irq stays pending, then ERET wins and irq waits out the shadow
        irq = 1; cycle();
        irq = 0; mem_en = 1; irq_en = 0;
        for (int c = 0; c < 2; c++) begin
            settle(); chk("irq_masked", save_exp, 1'b0); advance();
        end
        is_eret = 1; mepc_i = 32'h200; irq_en = 1;
        settle(); chk("eret_pc", new_pc, 32'h200); chk("eret_restore", {restore_exp, save_exp}, 2'b10); advance();
        is_eret = 0;
        settle(); chk("irq_shadow", save_exp, 1'b0); advance();
        settle(); chk("irq_after_shadow", {save_exp, exp_code}, {1'b1, IRQ_CODE}); advance();
        idle(); cycle();

        // reset mid-operation drops pending irq and owed registers
        irq = 1; mc_issue = 1; mc_rd_addr = 5'd12; cycle();
        idle(); reset_ = 1'b0;
        settle(); chk("rst_mid", {if_stall, save_exp}, 2'b00); advance();
        reset_ = 1'b1; mem_en = 1; irq_en = 1; src_used = 2'b01; src_addr = {5'd0, 5'd12};
        settle(); chk("rst_irq_clr", save_exp, 1'b0); chk("rst_sb_clr", if_stall, 1'b0); advance();

        for (int n = 0; n < 500; n++) begin
            rand_inputs();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
